sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Sequencing and guard controller for the BRAM-backed synchronous FIFO macro (512 × 36, 18Kb). It owns the macro's active-high reset and enforces the required idle/reset/recovery windows after system reset and on every flush. It gates the requester's push/pop so the macro never sees a write when full, a read when empty, or any enable during a reset window. It keeps an exact occupancy count and a sticky error flag for the requester side.

## Interface
- `DEPTH`, 512: macro capacity in entries.
- `PRE_CYCLES`, 4: cycles with both enables forced low before the macro reset asserts.
- `RST_CYCLES`, 5: cycles the macro reset is held high.
- `POST_CYCLES`, 2: cycles with both enables forced low after the macro reset drops.
- `CW`, $clog2(DEPTH)+1: occupancy width. Derived; do not override.

- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `flush_i` in 1: request a full macro reset, honoured only in READY.
- `push_i` in 1: requester write request.
- `pop_i` in 1: requester read request.
- `ready_o` out 1: high when the controller is in READY.
- `full_o` out 1: no push will be accepted this cycle.
- `empty_o` out 1: no pop will be accepted this cycle.
- `usage_o` out CW: number of entries held, 0..DEPTH.
- `err_o` out 1: sticky macro error indicator.
- `fifo_rst_o` out 1: macro RST, active-high.
- `fifo_wren_o` out 1: macro WREN.
- `fifo_rden_o` out 1: macro RDEN.
- `fifo_full_i` in 1: macro FULL.
- `fifo_empty_i` in 1: macro EMPTY.
- `fifo_wrerr_i` in 1: macro WRERR.
- `fifo_rderr_i` in 1: macro RDERR.

## Operation
- FSM states: PRE, RST, POST, READY. One down-counter is shared by the three timed states.
- `rst_ni` low at an edge sets state to PRE, counter to PRE_CYCLES-1, usage to 0 and err to 0. This applies in any state, including mid-operation.
- PRE leaves for RST when the counter reaches 0, and the counter reloads RST_CYCLES-1. RST leaves for POST the same way, reloading POST_CYCLES-1. POST goes to READY when the counter reaches 0.
- READY with `flush_i` goes to PRE and reloads the counter. A push or pop presented in the same cycle as the flush is dropped. `flush_i` outside READY is ignored.
- Register-decoded outputs:
  - `fifo_rst_o` = (state==RST).
  - `ready_o` = (state==READY).
- Accept logic is combinational from the current registered state and the inputs:
  - `full_o` = ~ready_o | (usage==DEPTH) | fifo_full_i.
  - `empty_o` = ~ready_o | (usage==0) | fifo_empty_i.
  - push_acc = push_i & ~full_o & ~flush_i. This drives `fifo_wren_o`.
  - pop_acc = pop_i & ~empty_o & ~flush_i. This drives `fifo_rden_o`.
- Usage update each edge in READY: +1 on push_acc only, −1 on pop_acc only, unchanged when both or neither. usage is cleared to 0 on entry to RST. It never wraps, because the accept gating makes overflow and underflow unreachable.
- Simultaneous push and pop:
  - When full: the pop is accepted and the push is rejected, so usage goes DEPTH → DEPTH−1.
  - When empty: the push is accepted and the pop is rejected, because there is no fall-through. usage goes 0 → 1.
- Requests rejected by gating are dropped silently. The requester must hold a request until its accept condition is seen.
- `err_o` is set when `fifo_wrerr_i` or `fifo_rderr_i` is high in READY. It is also set when `fifo_empty_i` is high while usage ≥ 2 in READY, which indicates a flag mismatch. It holds until reset or until a flush sequence enters RST.

## Timing
- Reset values:
  - state is PRE and `ready_o` is 0.
  - `fifo_rst_o` is 0.
  - `fifo_wren_o` and `fifo_rden_o` are 0.
  - `usage_o` and `err_o` are 0.
  - `full_o` and `empty_o` are 1.
- After the last edge with `rst_ni` low:
  - `fifo_rst_o` is high during cycles PRE_CYCLES+1 .. PRE_CYCLES+RST_CYCLES, i.e. cycles 5..9 with defaults.
  - `ready_o` rises at cycle PRE_CYCLES+RST_CYCLES+POST_CYCLES+1, i.e. cycle 12.
- Flush: the cycle after `flush_i` is sampled in READY, `ready_o` is 0. `ready_o` is high again 11 cycles later with defaults.
- Enables are zero-latency from `push_i`/`pop_i`. They are never high while state≠READY, including the whole PRE and POST windows.
- `usage_o` reflects an accepted operation one cycle after it is accepted.
- Macro read data appears on the macro's data output one cycle after `fifo_rden_o` (DO_REG=0). That data path is outside this block.

## Test plan
- Reset: hold `rst_ni` low 3 cycles, then release. Required: `fifo_rst_o` is high in exactly cycles 5–9; `ready_o` is first high at cycle 12; the enables stay 0 throughout, even with `push_i`=`pop_i`=1 held.
- Fill: 512 pushes in READY give `usage_o`=512 and `full_o`=1. The 513th push gives `fifo_wren_o`=0 and usage stays 512.
- Simultaneous at full: push+pop at usage 512 give wren=0, rden=1, and usage 511. Push+pop at usage 0 give wren=1, rden=0, and usage 1.
- Pop while empty: gives `fifo_rden_o`=0, usage stays 0, and `err_o` stays 0.
- Flush mid-stream: at usage 100, `flush_i` together with push. Required: the push is dropped; `ready_o` is 0 for 11 cycles; `fifo_rst_o` pulses for 5 cycles; `usage_o` is 0 on return to READY.
- Reset mid-sequence and error: assert `rst_ni` low during RST, and the sequence restarts from PRE with full timing. Force `fifo_wrerr_i`=1 for 1 cycle in READY, and `err_o`=1 must stay set until the next flush enters RST.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl
// Purpose  : Sequencing and guard controller for a BRAM-backed synchronous
//            FIFO macro. Runs the PRE/RST/POST reset windows after system
//            reset and on every flush. Gates requester push/pop so the macro
//            never sees a write when full, a read when empty, or any enable
//            during a reset window. Keeps an exact occupancy count and a
//            sticky error flag.
// Ports    : clk_i, rst_ni (sync, active-low)
//            flush_i, push_i, pop_i        - requester side
//            ready_o, full_o, empty_o      - requester status
//            usage_o, err_o                - occupancy / sticky error
//            fifo_rst_o, fifo_wren_o, fifo_rden_o                  - macro ctrl
//            fifo_full_i, fifo_empty_i, fifo_wrerr_i, fifo_rderr_i - macro flags
// Revision : 1.0 - initial release
// ============================================================================
module sram_fifo_ctrl #(
  parameter int DEPTH       = 512,
  parameter int PRE_CYCLES  = 4,
  parameter int RST_CYCLES  = 5,
  parameter int POST_CYCLES = 2,
  parameter int CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic          ready_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] usage_o,
  output logic          err_o,
  output logic          fifo_rst_o,
  output logic          fifo_wren_o,
  output logic          fifo_rden_o,
  input  logic          fifo_full_i,
  input  logic          fifo_empty_i,
  input  logic          fifo_wrerr_i,
  input  logic          fifo_rderr_i
);

  // Shared down-counter is sized for the longest of the three windows.
  localparam int c_max_cycles = (PRE_CYCLES > RST_CYCLES)
                              ? ((PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES)
                              : ((RST_CYCLES > POST_CYCLES) ? RST_CYCLES : POST_CYCLES);
  localparam int c_cnt_w = $clog2(c_max_cycles + 1);

  localparam logic [c_cnt_w-1:0] c_pre_load  = c_cnt_w'(PRE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rst_load  = c_cnt_w'(RST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_post_load = c_cnt_w'(POST_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [CW-1:0]      c_usage_max = CW'(DEPTH);
  localparam logic [CW-1:0]      c_usage_one = CW'(1);
  localparam logic [CW-1:0]      c_usage_two = CW'(2);

  typedef enum logic [1:0] {
    ST_PRE   = 2'd0,
    ST_RST   = 2'd1,
    ST_POST  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [CW-1:0]        r_usage;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_acc;
  logic                 w_pop_acc;
  logic                 w_flag_mismatch;

  // Status and accept gating are combinational from registered state so the
  // macro enables follow push_i/pop_i with zero latency.
  assign w_ready    = (r_state == ST_READY);
  assign w_full     = ~w_ready | (r_usage == c_usage_max) | fifo_full_i;
  assign w_empty    = ~w_ready | (r_usage == '0) | fifo_empty_i;
  assign w_push_acc = push_i & ~w_full  & ~flush_i;
  assign w_pop_acc  = pop_i  & ~w_empty & ~flush_i;

  // The macro EMPTY flag lags a write by a cycle or so; with two or more
  // entries held it can never legitimately be high.
  assign w_flag_mismatch = fifo_empty_i & (r_usage >= c_usage_two);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_PRE;
      r_cnt   <= c_pre_load;
      r_usage <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_PRE: begin
          if (r_cnt == '0) begin
            // Entering the macro reset: the macro forgets its contents here.
            r_state <= ST_RST;
            r_cnt   <= c_rst_load;
            r_usage <= '0;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_RST: begin
          if (r_cnt == '0) begin
            r_state <= ST_POST;
            r_cnt   <= c_post_load;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_POST: begin
          if (r_cnt == '0) begin
            r_state <= ST_READY;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        ST_READY: begin
          if (flush_i) begin
            r_state <= ST_PRE;
            r_cnt   <= c_pre_load;
          end
          // Accept gating makes wrap-around unreachable.
          if (w_push_acc && !w_pop_acc) begin
            r_usage <= r_usage + c_usage_one;
          end else if (w_pop_acc && !w_push_acc) begin
            r_usage <= r_usage - c_usage_one;
          end
          if (fifo_wrerr_i || fifo_rderr_i || w_flag_mismatch) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_PRE;
          r_cnt   <= c_pre_load;
        end
      endcase
    end
  end

  assign ready_o     = w_ready;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign usage_o     = r_usage;
  assign err_o       = r_err;
  assign fifo_rst_o  = (r_state == ST_RST);
  assign fifo_wren_o = w_push_acc;
  assign fifo_rden_o = w_pop_acc;

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_ctrl
// Purpose  : Self-checking bench for sram_fifo_ctrl. A reference model tracks
//            the position within the reset sequence, the occupancy and the
//            sticky error; each cycle's expected outputs are queued and a
//            separate monitor compares them against the DUT on the falling
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 512;
  localparam int PRE   = 4;
  localparam int RSTC  = 5;
  localparam int POST  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_ni, flush_i, push_i, pop_i;
  logic          ready_o, full_o, empty_o, err_o;
  logic [CW-1:0] usage_o;
  logic          fifo_rst_o, fifo_wren_o, fifo_rden_o;
  logic          fifo_full_i, fifo_empty_i, fifo_wrerr_i, fifo_rderr_i;

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (push_i),
    .pop_i        (pop_i),
    .ready_o      (ready_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .usage_o      (usage_o),
    .err_o        (err_o),
    .fifo_rst_o   (fifo_rst_o),
    .fifo_wren_o  (fifo_wren_o),
    .fifo_rden_o  (fifo_rden_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_wrerr_i (fifo_wrerr_i),
    .fifo_rderr_i (fifo_rderr_i)
  );

  typedef struct packed {
    logic          ready;
    logic          full;
    logic          empty;
    logic          wren;
    logic          rden;
    logic          frst;
    logic          err;
    logic [CW-1:0] usage;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pos = 0 means READY, otherwise the 1-based cycle index
  // within the PRE+RST+POST sequence.
  int   pos = 0;
  int   occ = 0;
  logic err_m = 1'b0;
  bit   model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expectation for the current cycle and compares.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready_o",     32'(ready_o),     32'(e.ready));
      chk("full_o",      32'(full_o),      32'(e.full));
      chk("empty_o",     32'(empty_o),     32'(e.empty));
      chk("fifo_wren_o", 32'(fifo_wren_o), 32'(e.wren));
      chk("fifo_rden_o", 32'(fifo_rden_o), 32'(e.rden));
      chk("fifo_rst_o",  32'(fifo_rst_o),  32'(e.frst));
      chk("err_o",       32'(err_o),       32'(e.err));
      chk("usage_o",     32'(usage_o),     32'(e.usage));
    end
  end

  // One clock cycle: drive inputs, queue the expectation, advance the model.
  task automatic step(input logic rn, fl, pu, po, ff, fe, we, re);
    exp_t e;
    logic rdy, f, em, acc_w, acc_r;
    rst_ni       = rn;
    flush_i      = fl;
    push_i       = pu;
    pop_i        = po;
    fifo_full_i  = ff;
    fifo_empty_i = fe;
    fifo_wrerr_i = we;
    fifo_rderr_i = re;
    rdy   = (pos == 0);
    f     = !rdy || (occ == DEPTH) || ff;
    em    = !rdy || (occ == 0) || fe;
    acc_w = pu && !f && !fl;
    acc_r = po && !em && !fl;
    if (model_valid) begin
      e.ready = rdy;
      e.full  = f;
      e.empty = em;
      e.wren  = acc_w;
      e.rden  = acc_r;
      e.frst  = (pos > PRE) && (pos <= PRE + RSTC);
      e.err   = err_m;
      e.usage = CW'(occ);
      q.push_back(e);
    end
    @(posedge clk);
    if (!rn) begin
      pos = 1;
      occ = 0;
      err_m = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (pos == 0) begin
        if (we || re || (fe && occ >= 2)) err_m = 1'b1;
        if (fl) pos = 1;
        else occ = occ + int'(acc_w) - int'(acc_r);
      end else begin
        pos++;
        if (pos == PRE + 1) begin
          occ = 0;
          err_m = 1'b0;
        end
        if (pos == PRE + RSTC + POST + 1) pos = 0;
      end
    end
    #1;
  endtask

  // Macro flags consistent with the modelled occupancy, no error strobes.
  task automatic go(input logic rn, fl, pu, po);
    step(rn, fl, pu, po, (occ == DEPTH), (occ == 0), 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", q.size());
    $fatal(1);
  end

  initial begin
    logic rn, fl, pu, po, ff, fe, we, re;
    rst_ni = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    fifo_full_i = 1'b0; fifo_empty_i = 1'b1; fifo_wrerr_i = 1'b0; fifo_rderr_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles with push/pop asserted throughout the sequence.
    repeat (3) go(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (PRE + RSTC + POST) go(1'b1, 1'b0, 1'b1, 1'b1);
    go(1'b1, 1'b0, 1'b0, 1'b0);

    // Fill to capacity, then one more push that must be refused.
    while (occ < DEPTH) go(1'b1, 1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b0, 1'b1, 1'b0);

    // Simultaneous push+pop at full, drain, simultaneous at empty.
    go(1'b1, 1'b0, 1'b1, 1'b1);
    while (occ > 0) go(1'b1, 1'b0, 1'b0, 1'b1);
    go(1'b1, 1'b0, 1'b1, 1'b1);
    go(1'b1, 1'b0, 1'b0, 1'b1);

    // Pop while empty.
    go(1'b1, 1'b0, 1'b0, 1'b1);
    go(1'b1, 1'b0, 1'b0, 1'b0);

    // Flush at usage 100 together with a push.
    while (occ < 100) go(1'b1, 1'b0, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (PRE + RSTC + POST + 1) go(1'b1, 1'b0, 1'b0, 1'b0);

    // Flush, then system reset while the macro reset is asserted.
    go(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) go(1'b1, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (PRE + RSTC + POST + 1) go(1'b1, 1'b0, 1'b0, 1'b0);

    // Write-error strobe: err stays set through PRE, clears on RST entry.
    repeat (3) go(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) go(1'b1, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (PRE + RSTC + POST + 1) go(1'b1, 1'b0, 1'b0, 1'b0);

    // Flag mismatch: macro EMPTY high with several entries held.
    repeat (4) go(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    go(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with alternating push-heavy / pop-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 999) != 0);
      fl = ($urandom_range(0, 149) == 0);
      if (((i / 400) % 2) == 0) begin
        pu = ($urandom_range(0, 9) < 7);
        po = ($urandom_range(0, 9) < 3);
      end else begin
        pu = ($urandom_range(0, 9) < 3);
        po = ($urandom_range(0, 9) < 7);
      end
      ff = (occ == DEPTH) || ($urandom_range(0, 19) == 0);
      fe = (occ == 0) || ($urandom_range(0, 29) == 0);
      we = ($urandom_range(0, 399) == 0);
      re = ($urandom_range(0, 399) == 0);
      step(rn, fl, pu, po, ff, fe, we, re);
    end

    go(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
